ring_meter_ctrl: RTL and testbench
==================================

RING_METER_CTRL -- requirements
Module: ring_meter_ctrl

Interface
REQ-001 SHALL have parameter pRINGS, default 6, number of ring oscillators controlled (legal 2..8).
REQ-002 SHALL have parameter pSETTLE, default 16, clock cycles a ring runs before counting starts (legal >=1).
REQ-003 SHALL have parameter pGATE, default 1024, clock cycles in the counting window (legal >=2).
REQ-004 SHALL have parameter pCNT_W, default 12, edge-counter width.
REQ-005 SHALL have port i_clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1, reset; synchronous, active-low.
REQ-007 SHALL have port i_ring, input, pRINGS, raw ring-oscillator outputs, asynchronous to i_clk.
REQ-008 SHALL have port i_sel, input, 3, index of the ring to measure; sampled on accepted start.
REQ-009 SHALL have port i_start, input, 1, measurement request.
REQ-010 SHALL have port i_abort, input, 1, cancel the measurement in progress.
REQ-011 SHALL have port o_ring_en, output, pRINGS, one-hot ring enable.
REQ-012 SHALL have port o_busy, output, 1, high in any state other than IDLE.
REQ-013 SHALL have port o_done, output, 1, one-cycle completion pulse.
REQ-014 SHALL have port o_count, output, pCNT_W, last completed edge count.
REQ-015 SHALL have port o_ovf, output, 1, last count saturated.
REQ-016 SHALL have port o_err, output, 1, last start rejected for out-of-range i_sel.

Function
REQ-017 SHALL implement FSM states IDLE, SETTLE, GATE and DONE.
REQ-018 IDLE: i_start=1 with i_sel<pRINGS SHALL latch i_sel, clear o_err, clear the edge counter and the ovf flag, and go to SETTLE on the next edge.
REQ-019 IDLE: i_start=1 with i_sel>=pRINGS SHALL set o_err=1 and stay in IDLE, leaving o_ring_en, o_count and o_ovf unchanged.
REQ-020 o_ring_en SHALL be one-hot on the latched index during SETTLE and GATE, and all-zero in IDLE and DONE.
REQ-021 SETTLE SHALL last exactly pSETTLE cycles, then go to GATE; edges seen during SETTLE are not counted.
REQ-022 GATE SHALL last exactly pGATE cycles, then go to DONE.
REQ-023 The selected ring bit SHALL pass through a 2-flop synchronizer plus 1 history flop, all free-running; a rising edge is sync2=1 and hist=0.
REQ-024 The counter SHALL increment by 1 for each rising edge detected during a GATE cycle, including the final GATE cycle.
REQ-025 The counter SHALL saturate at 2^pCNT_W-1; an increment attempted at saturation sets the ovf flag.
REQ-026 DONE SHALL last 1 cycle: o_done=1, o_count/o_ovf take the counter/flag value, then return to IDLE.
REQ-027 o_count/o_ovf SHALL hold until the next DONE.
REQ-028 Latency: with i_start accepted at edge k, o_done SHALL be high during cycle k+pSETTLE+pGATE+1.
REQ-029 i_start SHALL be ignored while o_busy=1.
REQ-030 i_abort=1 in SETTLE or GATE SHALL go to IDLE on the next edge, clear o_ring_en, give no o_done, and leave o_count/o_ovf unchanged.
REQ-031 i_abort SHALL take priority over the SETTLE-to-GATE and GATE-to-DONE transitions.
REQ-032 i_abort in IDLE or DONE SHALL have no effect.
REQ-033 i_start and i_abort both high in IDLE: i_start SHALL win.

Reset
REQ-034 i_rst_n=0 at a clock edge SHALL force state IDLE and o_ring_en=0, o_busy=0, o_done=0, o_count=0, o_ovf=0, o_err=0, counter=0, and all synchronizer and history flops=0.
REQ-035 Reset asserted mid-SETTLE or mid-GATE SHALL abandon the measurement with no o_done pulse, and the ring SHALL be disabled from the next edge.

Verification
REQ-036 Defaults, i_sel=2, i_ring[2] toggling every 4 clocks synchronously -> o_ring_en=6'b000100 through SETTLE/GATE; o_done at start+1041; o_count=128; o_ovf=0.
REQ-037 i_sel=7 start -> o_err=1, o_busy stays 0, o_ring_en=0, o_count unchanged.
REQ-038 pCNT_W=6, ring toggling every 2 clocks -> o_count=63, o_ovf=1.
REQ-039 i_abort at GATE cycle 500 -> IDLE next edge, no o_done, o_count keeps its previous value; a new start then completes normally.
REQ-040 Second i_start during GATE -> ignored, single o_done at the original time; i_rst_n=0 mid-GATE -> all outputs 0 on the next edge.
REQ-041 Constant-high ring, and ring edges only during SETTLE -> o_count=0.

Source files
------------

// File: rtl/ring_meter_ctrl.sv
// Ring-oscillator frequency meter: enables one ring, lets it settle,
// then counts its synchronized rising edges over a fixed gate window.
module ring_meter_ctrl #(
    parameter int pRINGS  = 6,
    parameter int pSETTLE = 16,
    parameter int pGATE   = 1024,
    parameter int pCNT_W  = 12
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [pRINGS-1:0] i_ring,
    input  logic [2:0]        i_sel,
    input  logic              i_start,
    input  logic              i_abort,
    output logic [pRINGS-1:0] o_ring_en,
    output logic              o_busy,
    output logic              o_done,
    output logic [pCNT_W-1:0] o_count,
    output logic              o_ovf,
    output logic              o_err
);

    localparam int SEL_W   = (pRINGS > 1) ? $clog2(pRINGS) : 1;
    localparam int TMR_MAX = (pSETTLE > pGATE) ? pSETTLE : pGATE;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(pSETTLE - 1);
    localparam logic [TMR_W-1:0]  GATE_LAST   = TMR_W'(pGATE - 1);
    localparam logic [3:0]        RINGS_N     = 4'(pRINGS);
    localparam logic [pCNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        GATE,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [SEL_W-1:0]  sel_q;
    logic [TMR_W-1:0]  tmr_q;
    logic [pCNT_W-1:0] cnt_q;
    logic [pCNT_W-1:0] cnt_nxt;
    logic              ovf_q;
    logic              ovf_nxt;
    logic              sync1_q;
    logic              sync2_q;
    logic              hist_q;

    logic sel_ok;
    logic accept;
    logic reject;
    logic rise;
    logic cnt_inc;
    logic cnt_sat;

    // Request qualification, edge detect and saturating counter next value
    always_comb begin
        sel_ok  = {1'b0, i_sel} < RINGS_N;
        accept  = (state_q == IDLE) && i_start && sel_ok;
        reject  = (state_q == IDLE) && i_start && !sel_ok;
        rise    = sync2_q && !hist_q;
        cnt_inc = (state_q == GATE) && rise;
        cnt_sat = (cnt_q == CNT_MAX);
        cnt_nxt = (cnt_inc && !cnt_sat) ? cnt_q + 1'b1 : cnt_q;
        ovf_nxt = ovf_q || (cnt_inc && cnt_sat);
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; abort outranks the timed transitions
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (accept) state_d = SETTLE;
            SETTLE: begin
                if (i_abort)         state_d = IDLE;
                else if (tmr_q == SETTLE_LAST) state_d = GATE;
            end
            GATE:   begin
                if (i_abort)         state_d = IDLE;
                else if (tmr_q == GATE_LAST) state_d = DONE;
            end
            DONE:   state_d = IDLE;
        endcase
    end

    // State-decoded outputs: status flags and one-hot ring enable
    always_comb begin
        o_busy    = (state_q != IDLE);
        o_done    = (state_q == DONE);
        o_ring_en = '0;
        if (state_q == SETTLE || state_q == GATE)
            o_ring_en[sel_q] = 1'b1;
    end

    // Cycles spent in the current state, restarted on every transition
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            tmr_q <= '0;
        else if (state_q != state_d)
            tmr_q <= '0;
        else if (state_q == SETTLE || state_q == GATE)
            tmr_q <= tmr_q + 1'b1;
    end

    // Ring index captured on an accepted start
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)    sel_q <= '0;
        else if (accept) sel_q <= i_sel[SEL_W-1:0];
    end

    // Free-running synchronizer and history flop on the selected ring
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= i_ring[sel_q];
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    // Working edge counter and its overflow flag
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_nxt;
            ovf_q <= ovf_nxt;
        end
    end

    // Result registers load on entry to DONE so they are valid with o_done
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_count <= '0;
            o_ovf   <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            if (accept)      o_err <= 1'b0;
            else if (reject) o_err <= 1'b1;
            if (state_q == GATE && state_d == DONE) begin
                o_count <= cnt_nxt;
                o_ovf   <= ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ring_meter_ctrl.sv
// Bench for ring_meter_ctrl: two parameter sets driven in parallel,
// each checked every cycle against a timeline-based reference model.
module tb_ring_meter_ctrl;

    localparam int R   = 6;
    localparam int PS0 = 16;
    localparam int PG0 = 1024;
    localparam int W0  = 12;
    localparam int PS1 = 3;
    localparam int PG1 = 300;
    localparam int W1  = 6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [R-1:0] ring;
    logic [2:0]   sel;
    logic         start;
    logic         abort;

    logic [R-1:0]  en0, en1;
    logic          busy0, busy1, done0, done1;
    logic [W0-1:0] cnt0;
    logic [W1-1:0] cnt1;
    logic          ovf0, ovf1, err0, err1;

    int  nchk  = 0;
    int  nfail = 0;
    bit  chk_on = 0;
    int  cyc   = 0;
    int  rmode = 3;
    int  half  = 4;

    ring_meter_ctrl #(.pRINGS(R), .pSETTLE(PS0), .pGATE(PG0), .pCNT_W(W0)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ring(ring), .i_sel(sel),
        .i_start(start), .i_abort(abort), .o_ring_en(en0), .o_busy(busy0),
        .o_done(done0), .o_count(cnt0), .o_ovf(ovf0), .o_err(err0)
    );

    ring_meter_ctrl #(.pRINGS(R), .pSETTLE(PS1), .pGATE(PG1), .pCNT_W(W1)) dut6 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ring(ring), .i_sel(sel),
        .i_start(start), .i_abort(abort), .o_ring_en(en1), .o_busy(busy1),
        .o_done(done1), .o_count(cnt1), .o_ovf(ovf1), .o_err(err1)
    );

    always #5 clk = ~clk;

    function automatic int ps(input int i);
        return (i == 0) ? PS0 : PS1;
    endfunction
    function automatic int pg(input int i);
        return (i == 0) ? PG0 : PG1;
    endfunction
    function automatic int cmax(input int i);
        return (i == 0) ? (1 << W0) - 1 : (1 << W1) - 1;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        nchk++;
        if (got != exp) begin
            nfail++;
            if (nfail <= 40)
                $display("FAIL %s got=%0d expected=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    // Ring stimulus: random, square wave of period 2*half, high or low
    always @(negedge clk) begin
        cyc++;
        case (rmode)
            0:       ring = R'($urandom);
            1:       ring = ((cyc / half) % 2 == 1) ? '1 : '0;
            2:       ring = '1;
            default: ring = '0;
        endcase
    end

    // Reference model: each measurement is a timeline of elapsed cycles
    bit act [2];
    int el  [2];
    int msel[2];
    int raw [2];
    int xcnt[2];
    bit xovf[2];
    bit xerr[2];
    bit b1  [2];
    bit b2  [2];
    bit b3  [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int sp;
            int last;
            bit rs;
            sp   = msel[i];
            rs   = b2[i] && !b3[i];
            last = ps(i) + pg(i);
            if (!rst_n) begin
                act[i] = 0; el[i] = 0; msel[i] = 0; raw[i] = 0;
                xcnt[i] = 0; xovf[i] = 0; xerr[i] = 0;
                b1[i] = 0; b2[i] = 0; b3[i] = 0;
            end else begin
                if (act[i]) begin
                    if (el[i] == last) act[i] = 0;
                    else if (abort) act[i] = 0;
                    else begin
                        if (el[i] >= ps(i) && rs) raw[i]++;
                        if (el[i] == last - 1) begin
                            xcnt[i] = (raw[i] > cmax(i)) ? cmax(i) : raw[i];
                            xovf[i] = raw[i] > cmax(i);
                        end
                        el[i]++;
                    end
                end else if (start) begin
                    if (int'(sel) < R) begin
                        act[i] = 1; el[i] = 0; msel[i] = int'(sel);
                        raw[i] = 0; xerr[i] = 0;
                    end else begin
                        xerr[i] = 1;
                    end
                end
                b3[i] = b2[i];
                b2[i] = b1[i];
                b1[i] = ring[sp];
            end
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                int last;
                int xen;
                last = ps(i) + pg(i);
                xen  = (act[i] && el[i] < last) ? (1 << msel[i]) : 0;
                chk($sformatf("busy%0d", i), i ? int'(busy1) : int'(busy0), int'(act[i]));
                chk($sformatf("done%0d", i), i ? int'(done1) : int'(done0),
                    (act[i] && el[i] == last) ? 1 : 0);
                chk($sformatf("en%0d", i), i ? int'(en1) : int'(en0), xen);
                chk($sformatf("count%0d", i), i ? int'(cnt1) : int'(cnt0), xcnt[i]);
                chk($sformatf("ovf%0d", i), i ? int'(ovf1) : int'(ovf0), int'(xovf[i]));
                chk($sformatf("err%0d", i), i ? int'(err1) : int'(err0), int'(xerr[i]));
            end
        end
    end

    task automatic do_start(input int s);
        @(negedge clk);
        sel   = 3'(s);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int i, input int bound, output int lat);
        lat = 0;
        while (!(i ? done1 : done0) && lat < bound) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("done%0d_timeout", i), i ? int'(done1) : int'(done0), 1);
    endtask

    initial begin
        int lat;
        int pulses;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        sel   = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_count", int'(cnt0), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_en", int'(en0), 0);
        rst_n  = 1'b1;
        chk_on = 1;

        // Default measurement, square wave of period 8
        rmode = 1; half = 4;
        do_start(2);
        repeat (20) @(negedge clk);
        chk("en_sel2", int'(en0), 4);
        wait_done(0, 5000, lat);
        chk("latency", 20 + lat, 1040);
        chk("count128", int'(cnt0), 128);
        chk("ovf128", int'(ovf0), 0);

        // Out-of-range select
        do_start(7);
        chk("err_sel7", int'(err0), 1);
        chk("busy_sel7", int'(busy0), 0);
        chk("en_sel7", int'(en0), 0);
        chk("keep_sel7", int'(cnt0), 128);

        // Saturation on the narrow instance
        half = 2;
        do_start(1);
        chk("err_clear", int'(err0), 0);
        wait_done(1, 2000, lat);
        chk("sat_count", int'(cnt1), 63);
        chk("sat_ovf", int'(ovf1), 1);
        wait_done(0, 2000, lat);
        chk("count256", int'(cnt0), 256);

        // Abort at GATE cycle 500, then a clean rerun
        do_start(3);
        repeat (PS0 + 500) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", int'(busy0), 0);
        chk("abort_en", int'(en0), 0);
        chk("abort_keep", int'(cnt0), 256);
        do_start(0);
        wait_done(0, 2000, lat);
        chk("rerun_count", int'(cnt0), 256);

        // Second start while busy is ignored
        do_start(4);
        repeat (100) @(negedge clk);
        do_start(5);
        wait_done(0, 2000, lat);
        chk("latency2", 102 + lat, 1040);
        pulses = 0;
        repeat (1100) begin
            @(negedge clk);
            if (done0) pulses++;
        end
        chk("extra_done", pulses, 0);

        // Reset in the middle of GATE
        do_start(2);
        repeat (300) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_busy", int'(busy0), 0);
        chk("mrst_en", int'(en0), 0);
        chk("mrst_count", int'(cnt0), 0);
        chk("mrst_done", int'(done0), 0);
        rst_n = 1'b1;

        // Constant-high ring
        rmode = 2;
        do_start(2);
        wait_done(0, 2000, lat);
        chk("const_high", int'(cnt0), 0);

        // Edges only while settling
        rmode = 1; half = 1;
        do_start(3);
        repeat (8) @(negedge clk);
        rmode = 3;
        wait_done(0, 2000, lat);
        chk("settle_only", int'(cnt0), 0);

        // Randomized traffic
        rmode = 0;
        repeat (20000) begin
            @(negedge clk);
            start = ($urandom % 16) == 0;
            sel   = 3'($urandom % 8);
            abort = ($urandom % 4000) == 0;
            rst_n = ($urandom % 5000) != 0;
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
